// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI Note On/Off parser with running status driving 8 note-held GPIO bits.
// Define MIDI_OMNI_EN to accept 8n/9n on all 16 channels.
module midi_note_decoder #(
   parameter int CHANNEL   = 0,
   parameter int BASE_NOTE = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] gpio_o,
   output logic       note_stb,
   output logic       note_on,
   output logic [6:0] note_num,
   output logic [6:0] note_vel,
   output logic       err_stb
);
   typedef enum logic [1:0] {IDLE, WAIT_KEY, WAIT_VEL} state_t;
   localparam logic [7:0] L_BASE = 8'(BASE_NOTE);
   state_t     r_state, w_state_nxt;
   logic       r_rs_valid, w_rs_valid_nxt;
   logic       r_rs_on, w_rs_on_nxt;
   logic [6:0] r_key, w_key_nxt;
   logic [7:0] r_gpio, w_gpio_nxt;
   logic       r_stb, r_on, r_err;
   logic [6:0] r_num, r_vel;
   logic       w_chan_ok, w_accept, w_rt, w_err, w_event, w_on, w_in_win;
   logic [7:0] w_idx, w_mask;
`ifdef MIDI_OMNI_EN
   assign w_chan_ok = 1'b1;
`else
   localparam logic [3:0] L_CHAN = 4'(CHANNEL);
   assign w_chan_ok = rx_data[3:0] == L_CHAN;
`endif
   assign w_accept = rx_data[7:5] == 3'b100 && w_chan_ok;
   assign w_rt     = rx_data[7:3] == 5'b11111;
   assign w_on     = r_rs_on && rx_data[6:0] != 7'd0;
   // Unsigned 8-bit distance from the window base; below-base keys wrap high and fall out.
   assign w_idx    = {1'b0, r_key} - L_BASE;
   assign w_in_win = {1'b0, r_key} >= L_BASE && w_idx < 8'd8;
   assign w_mask   = 8'd1 << w_idx[2:0];
   always_comb begin
      w_state_nxt    = r_state;
      w_rs_valid_nxt = r_rs_valid;
      w_rs_on_nxt    = r_rs_on;
      w_key_nxt      = r_key;
      w_err          = 1'b0;
      w_event        = 1'b0;
      if (rx_valid && !w_rt) begin
         if (rx_data[7]) begin
            w_err          = r_state != IDLE;
            w_rs_valid_nxt = w_accept;
            w_rs_on_nxt    = w_accept ? rx_data[4] : 1'b0;
            w_state_nxt    = w_accept ? WAIT_KEY : IDLE;
         end else if (r_state == WAIT_VEL) begin
            w_event     = 1'b1;
            w_state_nxt = WAIT_KEY;
         end else if (r_state == WAIT_KEY || r_rs_valid) begin
            w_key_nxt   = rx_data[6:0];
            w_state_nxt = WAIT_VEL;
         end
      end
      w_gpio_nxt = (w_event && w_in_win) ? (w_on ? r_gpio | w_mask : r_gpio & ~w_mask) : r_gpio;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_rs_valid <= 1'b0;
         r_rs_on    <= 1'b0;
         r_key      <= 7'd0;
         r_gpio     <= 8'd0;
         r_stb      <= 1'b0;
         r_on       <= 1'b0;
         r_num      <= 7'd0;
         r_vel      <= 7'd0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rs_valid <= w_rs_valid_nxt;
         r_rs_on    <= w_rs_on_nxt;
         r_key      <= w_key_nxt;
         r_gpio     <= w_gpio_nxt;
         r_stb      <= w_event;
         r_err      <= w_err;
         if (w_event) begin
            r_on  <= w_on;
            r_num <= r_key;
            r_vel <= rx_data[6:0];
         end
      end
   end
   assign gpio_o   = r_gpio;
   assign note_stb = r_stb;
   assign note_on  = r_on;
   assign note_num = r_num;
   assign note_vel = r_vel;
   assign err_stb  = r_err;
endmodule
